// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - wall register slot map, wall record type and reset values
package graphics_pkg;

   localparam int WALL_CW = 32;

   localparam int WALL_SLOT_X_MIN  = 0;
   localparam int WALL_SLOT_X_MAX  = 1;
   localparam int WALL_SLOT_Y_MIN  = 2;
   localparam int WALL_SLOT_Y_MAX  = 3;
   localparam int WALL_SLOT_COLOUR = 4;
   localparam int WALL_SLOT_ENABLE = 5;

   localparam logic [23:0] DEFAULT_COLOUR = 24'h15688E;

   typedef struct packed {
      logic [WALL_CW-1:0] x_min;
      logic [WALL_CW-1:0] x_max;
      logic [WALL_CW-1:0] y_min;
      logic [WALL_CW-1:0] y_max;
      logic [23:0]        colour;
      logic               enable;
   } wall_t;

   localparam wall_t WALL0_RESET = '{
      x_min:  32'd22,
      x_max:  32'd60,
      y_min:  32'd35,
      y_max:  32'd200,
      colour: DEFAULT_COLOUR,
      enable: 1'b1
   };

endpackage

// File: rtl/wall_hit_cmp.sv
// rtl/wall_hit_cmp.sv - combinational half-open rectangle hit test for one wall
module wall_hit_cmp
   import graphics_pkg::*;
(
   input  wall_t              i_wall,
   input  logic [WALL_CW-1:0] i_x,
   input  logic [WALL_CW-1:0] i_y,
   output logic               o_hit
);

   // Half-open bounds make an empty or inverted rectangle unable to hit.
   assign o_hit = i_wall.enable
                & (i_x >= i_wall.x_min) & (i_x < i_wall.x_max)
                & (i_y >= i_wall.y_min) & (i_y < i_wall.y_max);

endmodule

// File: rtl/walls_controller_multi.sv
// rtl/walls_controller_multi.sv - multi-wall renderer with shadow/active registers and 2-stage pixel pipeline
module walls_controller_multi
   import graphics_pkg::*;
#(
   parameter  int N_WALLS = 4,
   parameter  int COORD_W = 32,
   localparam int AW      = $clog2(N_WALLS) + 3
)(
   input  logic               clk,
   input  logic               rst_n_i,
   input  logic               MW_i,
   input  logic [AW-1:0]      address_i,
   input  logic [COORD_W-1:0] data_i,
   output logic [COORD_W-1:0] rd_data_o,
   input  logic               frame_start_i,
   input  logic               pix_valid_i,
   input  logic [COORD_W-1:0] x_pos_i,
   input  logic [COORD_W-1:0] y_pos_i,
   output logic               pix_valid_o,
   output logic               visible_o,
   output logic [3:0]         wall_idx_o,
   output logic [23:0]        RGB_o
);

   logic [1:0]         r_rst_sync;
   logic               w_rst_n;
   wall_t              r_shadow [N_WALLS];
   wall_t              r_active [N_WALLS];
   logic [3:0]         w_widx;
   logic [2:0]         w_slot;
   logic               w_addr_ok;
   logic [COORD_W-1:0] w_rd_next;
   logic [N_WALLS-1:0] w_hit;
   logic               r_s1_valid;
   logic [N_WALLS-1:0] r_s1_hit;
   logic [23:0]        r_s1_colour [N_WALLS];
   logic               w_win_vis;
   logic [3:0]         w_win_idx;
   logic [23:0]        w_win_rgb;

   // Reset asserts asynchronously and is released on a clock edge.
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_comb begin
      w_widx    = 4'(address_i >> 3);
      w_slot    = address_i[2:0];
      w_addr_ok = ({1'b0, w_widx} < 5'(N_WALLS)) && (w_slot < 3'd6);
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < N_WALLS; i++) r_shadow[i] <= (i == 0) ? WALL0_RESET : wall_t'(0);
      end else if (MW_i && w_addr_ok) begin
         for (int i = 0; i < N_WALLS; i++) begin
            if (w_widx == 4'(i)) begin
               case (w_slot)
                  3'(WALL_SLOT_X_MIN):  r_shadow[i].x_min  <= WALL_CW'(data_i);
                  3'(WALL_SLOT_X_MAX):  r_shadow[i].x_max  <= WALL_CW'(data_i);
                  3'(WALL_SLOT_Y_MIN):  r_shadow[i].y_min  <= WALL_CW'(data_i);
                  3'(WALL_SLOT_Y_MAX):  r_shadow[i].y_max  <= WALL_CW'(data_i);
                  3'(WALL_SLOT_COLOUR): r_shadow[i].colour <= 24'(data_i);
                  3'(WALL_SLOT_ENABLE): r_shadow[i].enable <= data_i[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Commit samples the shadow before any same-edge write lands.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < N_WALLS; i++) r_active[i] <= (i == 0) ? WALL0_RESET : wall_t'(0);
      end else if (frame_start_i) begin
         for (int i = 0; i < N_WALLS; i++) r_active[i] <= r_shadow[i];
      end
   end

   always_comb begin
      w_rd_next = '0;
      if (w_addr_ok) begin
         for (int i = 0; i < N_WALLS; i++) begin
            if (w_widx == 4'(i)) begin
               case (w_slot)
                  3'(WALL_SLOT_X_MIN):  w_rd_next = COORD_W'(r_shadow[i].x_min);
                  3'(WALL_SLOT_X_MAX):  w_rd_next = COORD_W'(r_shadow[i].x_max);
                  3'(WALL_SLOT_Y_MIN):  w_rd_next = COORD_W'(r_shadow[i].y_min);
                  3'(WALL_SLOT_Y_MAX):  w_rd_next = COORD_W'(r_shadow[i].y_max);
                  3'(WALL_SLOT_COLOUR): w_rd_next = COORD_W'(r_shadow[i].colour);
                  3'(WALL_SLOT_ENABLE): w_rd_next = COORD_W'(r_shadow[i].enable);
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) rd_data_o <= '0;
      else          rd_data_o <= w_rd_next;
   end

   for (genvar g = 0; g < N_WALLS; g++) begin : g_wall
      wall_hit_cmp u_cmp (
         .i_wall (r_active[g]),
         .i_x    (WALL_CW'(x_pos_i)),
         .i_y    (WALL_CW'(y_pos_i)),
         .o_hit  (w_hit[g])
      );
   end

   // Colours ride with the hit vector so a commit between stages cannot mix frames.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_hit   <= '0;
         for (int i = 0; i < N_WALLS; i++) r_s1_colour[i] <= '0;
      end else begin
         r_s1_valid <= pix_valid_i;
         r_s1_hit   <= w_hit;
         for (int i = 0; i < N_WALLS; i++) r_s1_colour[i] <= r_active[i].colour;
      end
   end

   always_comb begin
      w_win_vis = 1'b0;
      w_win_idx = '0;
      w_win_rgb = '0;
      for (int i = N_WALLS - 1; i >= 0; i--) begin
         if (r_s1_hit[i]) begin
            w_win_vis = 1'b1;
            w_win_idx = 4'(i);
            w_win_rgb = r_s1_colour[i];
         end
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         pix_valid_o <= 1'b0;
         visible_o   <= 1'b0;
         wall_idx_o  <= '0;
         RGB_o       <= '0;
      end else begin
         pix_valid_o <= r_s1_valid;
         visible_o   <= w_win_vis;
         wall_idx_o  <= w_win_idx;
         RGB_o       <= w_win_rgb;
      end
   end

endmodule

// File: tb/tb_walls_controller_multi.sv
// tb/tb_walls_controller_multi.sv - directed self-checking bench for walls_controller_multi
module tb_walls_controller_multi;

   localparam int N_WALLS = 3;
   localparam int COORD_W = 32;
   localparam int AW      = 5;

   logic               clk;
   logic               rst_n_i;
   logic               MW_i;
   logic [AW-1:0]      address_i;
   logic [COORD_W-1:0] data_i;
   logic [COORD_W-1:0] rd_data_o;
   logic               frame_start_i;
   logic               pix_valid_i;
   logic [COORD_W-1:0] x_pos_i;
   logic [COORD_W-1:0] y_pos_i;
   logic               pix_valid_o;
   logic               visible_o;
   logic [3:0]         wall_idx_o;
   logic [23:0]        RGB_o;

   int n_vec = 0;
   int n_err = 0;

   walls_controller_multi #(.N_WALLS(N_WALLS), .COORD_W(COORD_W)) dut (
      .clk           (clk),
      .rst_n_i       (rst_n_i),
      .MW_i          (MW_i),
      .address_i     (address_i),
      .data_i        (data_i),
      .rd_data_o     (rd_data_o),
      .frame_start_i (frame_start_i),
      .pix_valid_i   (pix_valid_i),
      .x_pos_i       (x_pos_i),
      .y_pos_i       (y_pos_i),
      .pix_valid_o   (pix_valid_o),
      .visible_o     (visible_o),
      .wall_idx_o    (wall_idx_o),
      .RGB_o         (RGB_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [AW-1:0] adr(input int idx, input int slot);
      return AW'(idx * 8 + slot);
   endfunction

   task automatic wr(input int idx, input int slot, input logic [31:0] d);
      MW_i = 1'b1; address_i = adr(idx, slot); data_i = d;
      tick();
      MW_i = 1'b0;
   endtask

   task automatic commit();
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
   endtask

   task automatic rd(input string tag, input int idx, input int slot, input logic [31:0] exp_v);
      address_i = adr(idx, slot);
      tick();
      chk(tag, rd_data_o, exp_v);
   endtask

   task automatic pix(input string tag, input int x, input int y,
                      input logic vis, input logic [3:0] idx, input logic [23:0] rgb);
      pix_valid_i = 1'b1; x_pos_i = x; y_pos_i = y;
      tick();
      pix_valid_i = 1'b0;
      tick();
      chk({tag, "/valid"}, 32'(pix_valid_o), 32'd1);
      chk({tag, "/vis"},   32'(visible_o),   32'(vis));
      chk({tag, "/idx"},   32'(wall_idx_o),  32'(idx));
      chk({tag, "/rgb"},   32'(RGB_o),       32'(rgb));
   endtask

   initial begin
      rst_n_i = 1'b0; MW_i = 1'b0; address_i = '0; data_i = '0;
      frame_start_i = 1'b0; pix_valid_i = 1'b0; x_pos_i = '0; y_pos_i = '0;
      tick(); tick(); tick();
      chk("rst/pix_valid", 32'(pix_valid_o), 32'd0);
      chk("rst/visible",   32'(visible_o),   32'd0);
      chk("rst/idx",       32'(wall_idx_o),  32'd0);
      chk("rst/rgb",       32'(RGB_o),       32'd0);
      chk("rst/rd_data",   rd_data_o,        32'd0);
      rst_n_i = 1'b1;
      repeat (4) tick();

      rd("rst/w0_xmin",   0, 0, 32'd22);
      rd("rst/w0_colour", 0, 4, 32'h0015688E);
      rd("rst/w0_enable", 0, 5, 32'd1);
      rd("rst/w1_enable", 1, 5, 32'd0);

      pix("w0_hit",     30, 100, 1'b1, 4'd0, 24'h15688E);
      pix("w0_xmax",    60, 100, 1'b0, 4'd0, 24'h0);
      pix("w0_corner",  22,  35, 1'b1, 4'd0, 24'h15688E);

      wr(1, 0, 100); wr(1, 1, 200); wr(1, 2, 50); wr(1, 3, 80);
      wr(1, 4, 32'hFF0000); wr(1, 5, 1);
      pix("w1_uncommitted", 150, 60, 1'b0, 4'd0, 24'h0);
      commit();
      pix("w1_committed",   150, 60, 1'b1, 4'd1, 24'hFF0000);
      rd("w1_xmin_rb", 1, 0, 32'd100);

      wr(1, 0, 0); wr(1, 1, 640); wr(1, 2, 0); wr(1, 3, 480); wr(1, 4, 32'h00FF00);
      commit();
      pix("ovl_w0_wins", 30, 100, 1'b1, 4'd0, 24'h15688E);
      pix("ovl_w1",     300, 300, 1'b1, 4'd1, 24'h00FF00);
      pix("ovl_x640",   640,  10, 1'b0, 4'd0, 24'h0);
      pix("ovl_y480",    10, 480, 1'b0, 4'd0, 24'h0);
      pix("ovl_edge",   639, 479, 1'b1, 4'd1, 24'h00FF00);

      MW_i = 1'b1; address_i = adr(1, 0); data_i = 400; frame_start_i = 1'b1;
      tick();
      MW_i = 1'b0; frame_start_i = 1'b0;
      pix("same_cyc_old",  300, 300, 1'b1, 4'd1, 24'h00FF00);
      rd("same_cyc_shadow", 1, 0, 32'd400);
      commit();
      pix("same_cyc_miss", 300, 300, 1'b0, 4'd0, 24'h0);
      pix("same_cyc_hit",  450, 300, 1'b1, 4'd1, 24'h00FF00);

      wr(1, 4, 32'h0000FF);
      pix_valid_i = 1'b1; x_pos_i = 450; y_pos_i = 300;
      tick();
      pix_valid_i = 1'b0; frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
      chk("midpipe/rgb", 32'(RGB_o), 32'h00FF00);
      pix("post_commit_blue", 450, 300, 1'b1, 4'd1, 24'h0000FF);

      wr(2, 4, 32'hABCDEF);
      tick();
      chk("rb/w2_colour", rd_data_o, 32'h00ABCDEF);
      rd("rb/slot6", 2, 6, 32'd0);
      wr(3, 0, 5);
      rd("rb/idx3",       3, 0, 32'd0);
      rd("rb/w0_intact",  0, 0, 32'd22);
      rd("rb/w2_intact",  2, 4, 32'h00ABCDEF);

      for (int k = 0; k < 8; k++) begin
         pix_valid_i = 1'b1; x_pos_i = 30; y_pos_i = 100;
         if (k == 3) begin
            chk("stream/valid_pre", 32'(pix_valid_o), 32'd1);
            chk("stream/rgb_pre",   32'(RGB_o),       32'h15688E);
         end
         if (k == 4) begin
            rst_n_i = 1'b0;
            #1;
            chk("stream/rst_valid", 32'(pix_valid_o), 32'd0);
            chk("stream/rst_vis",   32'(visible_o),   32'd0);
            chk("stream/rst_rgb",   32'(RGB_o),       32'd0);
         end
         tick();
      end
      pix_valid_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stream/idle_valid", 32'(pix_valid_o), 32'd0);
      end
      pix_valid_i = 1'b1; x_pos_i = 30; y_pos_i = 100;
      tick();
      pix_valid_i = 1'b0;
      chk("stream/lat1_valid", 32'(pix_valid_o), 32'd0);
      tick();
      chk("stream/lat2_valid", 32'(pix_valid_o), 32'd1);
      chk("stream/lat2_rgb",   32'(RGB_o),       32'h15688E);
      pix("stream/w1_reset", 300, 300, 1'b0, 4'd0, 24'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
